// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: load/start/done handshake and skewed feed bus between
// the array controller (master) and the systolic_feeder (slave).
// wr_row carries one bit beyond the row index so that out-of-range rows
// can be presented and rejected.
interface systolic_feeder_if #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 8
);
    localparam int ROW_W = $clog2(SIZE) + 1;

    logic                             wr_en;
    logic                             wr_sel;
    logic [ROW_W-1:0]                 wr_row;
    logic [SIZE*DATA_WIDTH-1:0]       wr_data;
    logic                             wr_drop;
    logic                             start;
    logic                             busy;
    logic                             done;
    logic                             acc_clear;
    logic [SIZE-1:0][DATA_WIDTH-1:0]  row_weights;
    logic [SIZE-1:0][DATA_WIDTH-1:0]  col_activations;

    modport master (
        output wr_en, wr_sel, wr_row, wr_data, start,
        input  wr_drop, busy, done, acc_clear, row_weights, col_activations
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_data, start,
        output wr_drop, busy, done, acc_clear, row_weights, col_activations
    );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers weight matrix A and activation matrix X, then on
// start streams them diagonally skewed into the systolic array, waits for the
// array to drain and pulses done.
// Optional feature macro: SYSTOLIC_FEEDER_DBUF_EN -- double-buffered A/X
// storage (load bank / feed bank swapped on start). Undefined: single bank,
// writes accepted only in IDLE.
module systolic_feeder #(
    parameter int SIZE         = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 3 * SIZE
) (
    input  logic             clk,
    input  logic             rst,
    systolic_feeder_if.slave bus
);
    localparam int RIDX_W   = $clog2(SIZE);
    localparam int ROW_W    = RIDX_W + 1;
    localparam int FEED_LEN = 2 * SIZE - 1;
    localparam int CNT_W    = $clog2(2 * SIZE + DRAIN_CYCLES + 1);
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    localparam int AW = RIDX_W + 1;   // {bank, row}
`else
    localparam int AW = RIDX_W;       // {row}
`endif

    typedef logic [SIZE-1:0][DATA_WIDTH-1:0] row_t;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;     // slice index in FEED, cycle index in DRAIN

    row_t             mem_a [2**AW];
    row_t             mem_x [2**AW];

    logic             wr_in_range;
    logic             wr_ok;
    logic [AW-1:0]    wr_addr;

    logic             feed_d, clr_d, busy_d, done_d, drop_d;
    row_t             rw_d, cx_d;

    assign wr_in_range = bus.wr_row < ROW_W'(SIZE);

`ifdef SYSTOLIC_FEEDER_DBUF_EN
    logic bank_sel;                   // bank currently feeding the array
    logic start_go;

    assign start_go = (state == S_IDLE) && bus.start;
    assign wr_ok    = bus.wr_en && wr_in_range;
    assign wr_addr  = {~bank_sel, bus.wr_row[RIDX_W-1:0]};

    // swap load/feed banks on the accepted start edge
    always_ff @(posedge clk) begin
        if (rst)           bank_sel <= 1'b0;
        else if (start_go) bank_sel <= ~bank_sel;
    end
`else
    assign wr_ok   = bus.wr_en && wr_in_range && (state == S_IDLE);
    assign wr_addr = bus.wr_row[RIDX_W-1:0];
`endif

    // matrix storage: not reset, writes suppressed while rst is high
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            if (bus.wr_sel) mem_x[wr_addr] <= bus.wr_data;
            else            mem_a[wr_addr] <= bus.wr_data;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // next-state and slice/drain counter
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt == CNT_W'(FEED_LEN - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // control outputs decoded from the next state so registered outputs
    // line up with the state they describe
    always_comb begin
        feed_d = (state_d == S_FEED);
        clr_d  = (state_d == S_CLEAR);
        busy_d = (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        drop_d = bus.wr_en && !wr_ok;
    end

    // per-lane skew: lane i sees element k = c - i of its row (A) or its
    // column (X); both lanes share the same validity window 0 <= c-i < SIZE
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [CNT_W-1:0] k;
        logic             hit;
        logic [AW-1:0]    a_addr, x_addr;

        assign k   = cnt_d - CNT_W'(i);
        assign hit = feed_d && (cnt_d >= CNT_W'(i)) && (k < CNT_W'(SIZE));
`ifdef SYSTOLIC_FEEDER_DBUF_EN
        assign a_addr = {bank_sel, RIDX_W'(i)};
        assign x_addr = {bank_sel, k[RIDX_W-1:0]};
`else
        assign a_addr = RIDX_W'(i);
        assign x_addr = k[RIDX_W-1:0];
`endif
        assign rw_d[i] = hit ? mem_a[a_addr][k[RIDX_W-1:0]] : '0;
        assign cx_d[i] = hit ? mem_x[x_addr][i] : '0;
    end

    // registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.acc_clear       <= 1'b0;
            bus.wr_drop         <= 1'b0;
            bus.row_weights     <= '0;
            bus.col_activations <= '0;
        end else begin
            bus.busy            <= busy_d;
            bus.done            <= done_d;
            bus.acc_clear       <= clr_d;
            bus.wr_drop         <= drop_d;
            bus.row_weights     <= rw_d;
            bus.col_activations <= cx_d;
        end
    end
endmodule
